// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and arbitration mode constants for arbitor_n
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
endpackage

// File: rtl/arbitor_n_if.sv
// arbitor_n_if: request/grant bundle between requesters and the arbiter
// req/finish flow from the requester side; gnt, sel, busy, timeout_err, owner come back.
// master = requester/channel-manager side, slave = arbiter side.
interface arbitor_n_if #(
  parameter int NREQ = 3
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] sel;
  logic finish;
  logic busy;
  logic timeout_err;
  logic [IW-1:0] owner;
  modport master (output req, finish, input gnt, sel, busy, timeout_err, owner);
  modport slave (input req, finish, output gnt, sel, busy, timeout_err, owner);
endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational winner picker, first set request at or above ptr (wrapping)
// req: request vector, ptr: search start index (tie to 0 for fixed priority)
// win: one-hot winner or 0, idx: binary index of the winner
module arb_pick #(
  parameter int NREQ = 3,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] rot;
  logic hit;
  // rotating the doubled vector puts index ptr at bit 0, so a plain priority encode wraps
  assign rot = NREQ'({req, req} >> ptr);
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) begin
        hit = 1'b1;
        idx = IW'((i + int'(ptr)) % NREQ);
      end
    win = hit ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/arbitor_n.sv
// arbitor_n: N-way channel arbiter holding each grant until finish, with optional hold watchdog
// clk, rst: clock and asynchronous active-high reset
// bus (slave): req/finish in; gnt/sel one-hot registered, busy in GRANT,
//   timeout_err one-cycle pulse on forced release, owner = current/last owner index
module arbitor_n
  import arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  arbitor_n_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nxt;
  logic [NREQ-1:0] gnt_q, win;
  logic [IW-1:0] owner_q, ptr_q, ptr_use, idx;
  logic [CNT_W-1:0] cnt_q;
  logic terr_q, take, expire;
  assign ptr_use = (RR_MODE == ARB_RR) ? ptr_q : '0;
  arb_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .ptr(ptr_use),
    .win(win),
    .idx(idx)
  );
  // finish has priority over the watchdog in the same cycle
  assign expire = (state == GRANT) && (TIMEOUT != 0) && !bus.finish && (cnt_q == CNT_W'(TIMEOUT - 1));
  always_comb begin
    state_nxt = state;
    take = 1'b0;
    case (state)
      IDLE: begin
        take = |bus.req;
        state_nxt = take ? GRANT : IDLE;
      end
      GRANT: state_nxt = (bus.finish || expire) ? RELEASE : GRANT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      terr_q <= expire;
      if (take) begin
        gnt_q <= win;
        owner_q <= idx;
        ptr_q <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        cnt_q <= '0;
      end else if (state == GRANT) begin
        gnt_q <= (state_nxt == GRANT) ? gnt_q : '0;
        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.sel = gnt_q;
  assign bus.busy = (state == GRANT);
  assign bus.timeout_err = terr_q;
  assign bus.owner = owner_q;
endmodule

// File: tb/tb_arbitor_n.sv
// tb_arbitor_n: checks three arbiter configurations against a phase-level reference model
module tb_arbitor_n;
  import arb_pkg::*;
  localparam int ND = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int n_of [ND] = '{3, 3, 5};
  int rr_of [ND] = '{1, 0, 1};
  int to_of [ND] = '{8, 0, 16};
  logic [15:0] req_v [ND];
  logic fin_v [ND];
  logic [15:0] o_gnt [ND];
  logic [15:0] o_sel [ND];
  logic [3:0] o_own [ND];
  logic o_busy [ND];
  logic o_terr [ND];
  // model: phase 0 idle, 1 granted, 2 dead cycle
  int m_ph [ND];
  int m_own [ND];
  int m_ptr [ND];
  int m_cnt [ND];
  bit m_terr [ND];
  arbitor_n_if #(.NREQ(3)) bus_a ();
  arbitor_n_if #(.NREQ(3)) bus_b ();
  arbitor_n_if #(.NREQ(5)) bus_c ();
  arbitor_n #(.NREQ(3), .RR_MODE(ARB_RR), .TIMEOUT(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  arbitor_n #(.NREQ(3), .RR_MODE(ARB_FIXED), .TIMEOUT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  arbitor_n #(.NREQ(5), .RR_MODE(ARB_RR), .TIMEOUT(16)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  assign bus_a.req = req_v[0][2:0];
  assign bus_b.req = req_v[1][2:0];
  assign bus_c.req = req_v[2][4:0];
  assign bus_a.finish = fin_v[0];
  assign bus_b.finish = fin_v[1];
  assign bus_c.finish = fin_v[2];
  assign o_gnt[0] = 16'(bus_a.gnt);
  assign o_gnt[1] = 16'(bus_b.gnt);
  assign o_gnt[2] = 16'(bus_c.gnt);
  assign o_sel[0] = 16'(bus_a.sel);
  assign o_sel[1] = 16'(bus_b.sel);
  assign o_sel[2] = 16'(bus_c.sel);
  assign o_own[0] = 4'(bus_a.owner);
  assign o_own[1] = 4'(bus_b.owner);
  assign o_own[2] = 4'(bus_c.owner);
  assign o_busy[0] = bus_a.busy;
  assign o_busy[1] = bus_b.busy;
  assign o_busy[2] = bus_c.busy;
  assign o_terr[0] = bus_a.timeout_err;
  assign o_terr[1] = bus_b.timeout_err;
  assign o_terr[2] = bus_c.timeout_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_ph[d] = 0;
      m_own[d] = 0;
      m_ptr[d] = 0;
      m_cnt[d] = 0;
      m_terr[d] = 1'b0;
    end
  endtask

  function automatic int pick(int d);
    int base = rr_of[d] != 0 ? m_ptr[d] : 0;
    for (int k = 0; k < n_of[d]; k++)
      if (req_v[d][(base + k) % n_of[d]]) return (base + k) % n_of[d];
    return -1;
  endfunction

  task automatic model_step(int d);
    int w;
    m_terr[d] = 1'b0;
    if (m_ph[d] == 0) begin
      w = pick(d);
      if (w >= 0) begin
        m_ph[d] = 1;
        m_own[d] = w;
        m_ptr[d] = (w + 1) % n_of[d];
        m_cnt[d] = 0;
      end
    end else if (m_ph[d] == 1) begin
      if (fin_v[d]) m_ph[d] = 2;
      else if (to_of[d] != 0 && m_cnt[d] == to_of[d] - 1) begin
        m_ph[d] = 2;
        m_terr[d] = 1'b1;
      end else m_cnt[d]++;
    end else m_ph[d] = 0;
  endtask

  task automatic check_all();
    logic [15:0] e;
    for (int d = 0; d < ND; d++) begin
      e = (m_ph[d] == 1) ? 16'(16'd1 << m_own[d]) : 16'd0;
      chk($sformatf("gnt%0d", d), o_gnt[d], e);
      chk($sformatf("sel%0d", d), o_sel[d], e);
      chk($sformatf("busy%0d", d), o_busy[d], m_ph[d] == 1);
      chk($sformatf("terr%0d", d), o_terr[d], m_terr[d]);
      chk($sformatf("owner%0d", d), o_own[d], m_own[d]);
      chk($sformatf("inv%0d", d), {30'd0, $onehot0(o_gnt[d]), o_sel[d] == o_gnt[d]}, 32'd3);
    end
  endtask

  task automatic step(int k);
    repeat (k) begin
      @(posedge clk);
      if (rst) model_reset();
      else for (int d = 0; d < ND; d++) model_step(d);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic wait_gnt(int d, output logic [15:0] g, output int n);
    n = 0;
    while (o_gnt[d] == 0 && n < 20) begin
      step(1);
      n++;
    end
    g = o_gnt[d];
    chk($sformatf("wait_gnt%0d", d), 32'(g != 0), 1);
  endtask

  task automatic release_all();
    for (int d = 0; d < ND; d++) begin
      req_v[d] = '0;
      fin_v[d] = 1'b1;
    end
    step(1);
    for (int d = 0; d < ND; d++) fin_v[d] = 1'b0;
    step(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] gv;
    logic [15:0] ord [4];
    int n, pulses, at;
    ord = '{16'h1, 16'h2, 16'h4, 16'h1};
    for (int d = 0; d < ND; d++) begin
      req_v[d] = '0;
      fin_v[d] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    step(2);
    rst = 1'b0;
    step(1);
    req_v[0] = 16'h7;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(0, gv, n);
      chk("rr_order", gv, ord[g]);
      chk("rr_latency", n, g == 0 ? 1 : 2);
      step(3);
      fin_v[0] = 1'b1;
      step(1);
      fin_v[0] = 1'b0;
      chk("rr_release", o_gnt[0], 0);
    end
    req_v[0] = '0;
    step(2);
    req_v[1] = 16'h6;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(1, gv, n);
      chk("fixed_gnt", gv, 16'h2);
      step(2);
      fin_v[1] = 1'b1;
      step(1);
      fin_v[1] = 1'b0;
    end
    req_v[1] = '0;
    step(2);
    req_v[1] = 16'h1;
    step(1);
    chk("single_gnt", o_gnt[1], 1);
    chk("single_owner", o_own[1], 0);
    step(8);
    fin_v[1] = 1'b1;
    step(1);
    fin_v[1] = 1'b0;
    chk("single_rel", o_gnt[1], 0);
    step(1);
    chk("single_idle", o_gnt[1], 0);
    step(1);
    chk("single_regnt", o_gnt[1], 1);
    release_all();
    req_v[0] = 16'h3;
    wait_gnt(0, gv, n);
    chk("to_first", gv, 16'h2);
    pulses = 0;
    at = 0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (o_terr[0]) begin
        pulses++;
        at = c;
      end
    end
    chk("to_pulses", pulses, 1);
    chk("to_when", at, 8);
    chk("to_next", o_gnt[0], 16'h1);
    step(5);
    fin_v[0] = 1'b1;
    step(1);
    fin_v[0] = 1'b0;
    chk("to_coincide_terr", o_terr[0], 0);
    chk("to_coincide_gnt", o_gnt[0], 0);
    release_all();
    req_v[0] = 16'h2;
    wait_gnt(0, gv, n);
    chk("rst_pre", gv, 16'h2);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_gnt", o_gnt[0], 0);
    chk("rst_async_sel", o_sel[0], 0);
    chk("rst_async_busy", o_busy[0], 0);
    model_reset();
    step(1);
    rst = 1'b0;
    req_v[0] = 16'h6;
    step(1);
    chk("rst_ptr", o_gnt[0], 16'h2);
    release_all();
    req_v[2] = 16'h10;
    wait_gnt(2, gv, n);
    chk("wrap_first", gv, 16'h10);
    req_v[2] = 16'h11;
    fin_v[2] = 1'b1;
    step(1);
    fin_v[2] = 1'b0;
    wait_gnt(2, gv, n);
    chk("wrap_next", gv, 16'h1);
    release_all();
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < ND; d++) begin
        req_v[d] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom) & 16'((1 << n_of[d]) - 1);
        fin_v[d] = ($urandom_range(0, 5) == 0);
      end
      step(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
